relu_maxpool: RTL and testbench

Post-filter stage that consumes the signed 8-bit smoothed sample stream and its one-cycle valid strobe from the 3-tap (1/4, 1/2, 1/4) smoothing filter. It applies ReLU to each sample, reduces non-overlapping windows of POOL samples to their maximum, and emits one pooled sample per window with a one-cycle strobe and a running output index. A flush input closes a partial window at end of frame.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/relu_max8.sv | 27 ++
 rtl/relu_maxpool.sv | 100 ++++++++++
 tb/tb_relu_maxpool.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared types, defaults and helpers for the CNN post-filter stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } pool_state_t;

    localparam int POOL_DEFAULT = 2;
    localparam int IDXW_DEFAULT = 8;

    function automatic logic signed [7:0] relu8(input logic signed [7:0] v, input logic en);
        return (en && v < 0) ? 8'sd0 : v;
    endfunction

    function automatic logic signed [7:0] smax8(input logic signed [7:0] a, input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/relu_max8.sv
// ============================================================================
// Module   : relu_max8
// Brief    : Combinational ReLU on b, then signed max against a (or pass-through).
// Revision : 1.0
// ============================================================================
`default_nettype none

module relu_max8
    import cnn_pkg::*;
#(
    parameter int RELU_EN = 1
) (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    input  logic              first,
    output logic signed [7:0] y
);

    logic signed [7:0] w_v;

    assign w_v = relu8(b, RELU_EN != 0);
    // The first sample of a window replaces the stale running max outright.
    assign y   = first ? w_v : smax8(a, w_v);

endmodule

`default_nettype wire

// File: rtl/relu_maxpool.sv
// ============================================================================
// Module   : relu_maxpool
// Brief    : ReLU + non-overlapping max pooling with flush and output index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int POOL    = POOL_DEFAULT,
    parameter int IDXW    = IDXW_DEFAULT,
    parameter int RELU_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [7:0]      in,
    input  logic                   i_en,
    input  logic                   flush,
    output logic signed [7:0]      out,
    output logic                   o_en,
    output logic [IDXW-1:0]        o_idx
);

    localparam int c_cnt_w = 4;
    localparam logic [c_cnt_w-1:0] c_pool = c_cnt_w'(POOL);

    pool_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic signed [7:0]    r_mx, w_mx_cand, w_mx_nxt;
    logic                 w_close;
    logic signed [7:0]    r_out;
    logic                 r_o_en;
    logic [IDXW-1:0]      r_idx;

    relu_max8 #(
        .RELU_EN (RELU_EN)
    ) u_relu_max8 (
        .a     (r_mx),
        .b     (in),
        .first (r_state == S_IDLE),
        .y     (w_mx_cand)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mx    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mx    <= w_mx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mx_nxt    = r_mx;
        w_close     = 1'b0;
        if (i_en) begin
            w_mx_nxt    = w_mx_cand;
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = S_FILL;
        end
        // A same-cycle sample is already folded into w_mx_nxt before closing.
        if ((i_en && w_cnt_inc == c_pool) || (flush && (i_en || r_state == S_FILL))) begin
            w_close     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_o_en <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_o_en <= w_close;
            if (w_close) begin
                r_out <= w_mx_nxt;
            end
            // Index advances after the pulse so the pulse carries the old count.
            if (r_o_en) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign out   = r_out;
    assign o_en  = r_o_en;
    assign o_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool.sv
// ============================================================================
// Module   : tb_relu_maxpool
// Brief    : Scoreboard bench driving three relu_maxpool configurations at once.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_relu_maxpool;

    typedef struct {
        int v;
        int idx;
    } exp_t;

    localparam int P_POOL [3] = '{2, 3, 2};
    localparam int P_RELU [3] = '{1, 1, 0};
    localparam int P_IDXM [3] = '{256, 256, 4};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] s_in = '0;
    logic              s_en = 1'b0;
    logic              s_flush = 1'b0;

    logic signed [7:0] out0, out1, out2;
    logic              en0, en1, en2;
    logic [7:0]        idx0, idx1;
    logic [1:0]        idx2;

    int checks = 0;
    int failures = 0;

    int   m_cnt [3];
    int   m_mx  [3];
    int   m_idx [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;

    relu_maxpool #(.POOL(2), .IDXW(8), .RELU_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .in(s_in), .i_en(s_en), .flush(s_flush),
        .out(out0), .o_en(en0), .o_idx(idx0));
    relu_maxpool #(.POOL(3), .IDXW(8), .RELU_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .in(s_in), .i_en(s_en), .flush(s_flush),
        .out(out1), .o_en(en1), .o_idx(idx1));
    relu_maxpool #(.POOL(2), .IDXW(2), .RELU_EN(0)) u_dut2 (
        .clk(clk), .rst(rst), .in(s_in), .i_en(s_en), .flush(s_flush),
        .out(out2), .o_en(en2), .o_idx(idx2));

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int k, input int v, input int idx);
        exp_t e;
        e.v   = v;
        e.idx = idx;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic model_step(input int d, input logic e, input logic f);
        for (int k = 0; k < 3; k++) begin
            int v;
            v = (P_RELU[k] != 0 && d < 0) ? 0 : d;
            if (e) begin
                m_mx[k] = (m_cnt[k] == 0 || v > m_mx[k]) ? v : m_mx[k];
                m_cnt[k]++;
            end
            if ((e && m_cnt[k] == P_POOL[k]) || (f && m_cnt[k] > 0)) begin
                push(k, m_mx[k], m_idx[k]);
                m_idx[k] = (m_idx[k] + 1) % P_IDXM[k];
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_mx[k]  = 0;
            m_idx[k] = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic drive(input int d, input logic e, input logic f);
        s_in    = 8'(d);
        s_en    = e;
        s_flush = f;
        model_step(d, e, f);
        @(posedge clk);
        #1;
        s_in    = '0;
        s_en    = 1'b0;
        s_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
    endtask

    task automatic mon(input int k, input logic en, input int o, input int ix);
        exp_t e;
        if (!en) return;
        case (k)
            0: begin
                if (q0.size() == 0) begin check("extra_pulse0", 1, 0); return; end
                e = q0.pop_front();
            end
            1: begin
                if (q1.size() == 0) begin check("extra_pulse1", 1, 0); return; end
                e = q1.pop_front();
            end
            default: begin
                if (q2.size() == 0) begin check("extra_pulse2", 1, 0); return; end
                e = q2.pop_front();
            end
        endcase
        check($sformatf("out%0d", k), o, e.v);
        check($sformatf("idx%0d", k), ix, e.idx);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, en0, int'(out0), int'(idx0));
            mon(1, en1, int'(out1), int'(idx1));
            mon(2, en2, int'(out2), int'(idx2));
        end
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", int'(out0), 0);
        check("rst_en0", int'(en0), 0);
        check("rst_idx0", int'(idx0), 0);
        check("rst_out1", int'(out1), 0);
        check("rst_en1", int'(en1), 0);
        check("rst_idx1", int'(idx1), 0);
        check("rst_out2", int'(out2), 0);
        check("rst_en2", int'(en2), 0);
        check("rst_idx2", int'(idx2), 0);
        rst = 1'b1;
        idle(2);

        drive(5, 1'b1, 1'b0);
        drive(-3, 1'b1, 1'b0);
        idle(2);
        drive(-7, 1'b1, 1'b0);
        drive(-2, 1'b1, 1'b0);
        drive(127, 1'b1, 1'b0);
        drive(100, 1'b1, 1'b0);
        idle(2);
        drive(0, 1'b0, 1'b1);
        idle(1);

        drive(9, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b1);
        drive(6, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1);
        idle(2);
        drive(0, 1'b0, 1'b1);
        idle(2);
        drive(4, 1'b1, 1'b1);
        idle(2);

        drive(77, 1'b1, 1'b0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        drive(3, 1'b1, 1'b0);
        drive(8, 1'b1, 1'b0);
        idle(1);
        drive(0, 1'b0, 1'b1);
        idle(2);

        drive(-50, 1'b1, 1'b0);
        drive(-20, 1'b1, 1'b0);
        idle(1);
        drive(0, 1'b0, 1'b1);
        idle(1);
        for (int w = 0; w < 5; w++) begin
            drive(w * 10 - 20, 1'b1, 1'b0);
            drive(-w, 1'b1, 1'b0);
        end
        drive(0, 1'b0, 1'b1);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            drive(int'($signed(8'($urandom_range(0, 255)))),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        drive(0, 1'b0, 1'b1);
        idle(4);

        check("pending0", q0.size(), 0);
        check("pending1", q1.size(), 0);
        check("pending2", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
